uart_port_responder: RTL and testbench
======================================

// Module: uart_port_responder
// PURPOSE
//  Bus-side responder for one serial port in the 0xFF21_02x0 IO window: the device that a per-port
//  chip enable from the serial IO address decoder selects. Implements a 16550-subset register file,
//  fixed 8N1 transmitter and receiver, one FIFO per direction and an interrupt request line.
//  One instance per port (RS232, GPS, Bluetooth, WiFi); registers on even bytes, data on D15-D8.
// PARAMETERS
//  FIFO_DEPTH       16   entries per TX and RX FIFO (power of 2, >=2)
//  DEFAULT_DIVISOR  27   reset value of {DLM,DLL}; 50 MHz / (16*27) ~ 115200 baud
// PORTS
//  Clock        in   1  system clock; all state on rising edge
//  Reset_L      in   1  synchronous, active-low reset
//  Port_Enable  in   1  chip enable from the address decoder (Address in port block, ByteSelect_L=0)
//  Address      in   4  A3:A0; register index = A3:A1, A0 ignored
//  WE_L         in   1  0 = write, 1 = read; sampled with Port_Enable
//  DataIn       in   8  write data (bus D15-D8)
//  DataOut      out  8  read data; combinational from index; 0x00 when Port_Enable=0
//  TxD          out  1  serial out, idle high
//  RxD          in   1  serial in, asynchronous
//  IRQ          out  1  interrupt request, active high
// BEHAVIOUR
//  Reset: TxD=1, IRQ=0, DataOut=0, FIFOs empty, IER=0, LCR=0x03, divisor=DEFAULT_DIVISOR, LSR=0x60.
//  Access: commits exactly once per access, on first cycle Port_Enable is 1 after being 0 (edge-
//   detected); held enable for many cycles = one access. Read data valid for whole enable period.
//  Register map (index): 0 R RBR (pop RX) / W THR (push TX); DLL when LCR[7]=1
//   1 R/W IER[1:0] (bit0 RX data, bit1 THRE); DLM when LCR[7]=1
//   2 R IIR: 0xC4 RX data pending, else 0xC2 THRE pending, else 0xC1; W FCR: bit1 clr RX, bit2 clr TX
//   3 R/W LCR; only bit7 (DLAB) acts, others stored; framing fixed 8N1
//   5 R LSR: b0 DR, b1 OE, b3 FE, b5 THRE (TX FIFO empty), b6 TEMT (FIFO and shifter empty)
//   other indices: read 0x00, writes ignored.
//  RBR read on empty FIFO returns 0x00, no pop. THR write on full FIFO is dropped.
//  LSR read clears OE and FE after the access; a same-cycle new error still sets them.
//  Baud: 16-bit divisor counter emits tick16 when count = divisor-1; divisor 0 => no ticks,
//   TX and RX hold state. Divisor write restarts counter at 0.
//  TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE; each bit = 16 ticks; leaves IDLE on a tick
//   when FIFO non-empty; back-to-back bytes with no idle gap.
//  RX: 2-flop synchroniser; IDLE->START on 1->0; at tick 8 start must still be 0 else IDLE;
//   DATA samples mid-bit every 16 ticks; STOP sample 0 sets FE, byte still stored.
//   FIFO full at store: byte dropped, OE set.
//  Simultaneous push+pop in one cycle on same FIFO: both happen, count unchanged.
//  FCR clear same cycle as a push: clear wins, FIFO empty after. Clear does not abort shifter.
//  IRQ = (IER[0] & DR) | (IER[1] & THRE); registered, one cycle after cause.
//  Reset_L low mid-frame: everything returns to reset values next edge; TxD high immediately.
// STRUCTURE
//  Package uart_port_pkg: register index constants, LSR/IIR bit positions, IIR codes, FSM state enums.
//  Sub-module uart_sync_fifo (DEPTH, WIDTH=8): push/pop/clear, full/empty/count; instanced twice.
//  Baud generator, TX FSM, RX FSM, register file inline in this module.
// TESTING
//  Reset, read index 5 -> 0x60; index 3 -> 0x03; IRQ=0, TxD=1 held.
//  Divisor 27, write THR 0x55 -> TxD frame 0,10101010,1, each bit 432 clocks; LSR b6 set after stop.
//  RxD drives 0xA3 at divisor 27 -> LSR b0=1; RBR read 0xA3 once though enable held 5 cycles; DR=0.
//  17 RX bytes, no reads -> 16 stored, OE=1; LSR read clears OE; 1st RBR = 1st byte sent.
//  RxD glitch low 4 tick16 periods -> no byte, DR=0; stop bit driven 0 -> FE=1, byte stored.
//  IER=0x02, FIFO empty -> IRQ=1; write THR -> IRQ=0 next cycle; IIR=0xC2 once drained.

Source files
------------

// File: rtl/uart_port_pkg.sv
// Shared constants for the serial port responder.
// Register indices (Address[3:1]), LSR/LCR/FCR bit positions, IIR codes
// and the TX/RX state encodings.
package uart_port_pkg;

   localparam logic [2:0] IDX_RBR_THR = 3'd0;
   localparam logic [2:0] IDX_IER     = 3'd1;
   localparam logic [2:0] IDX_IIR_FCR = 3'd2;
   localparam logic [2:0] IDX_LCR     = 3'd3;
   localparam logic [2:0] IDX_LSR     = 3'd5;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_FE   = 3;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam int LCR_DLAB   = 7;
   localparam int FCR_CLR_RX = 1;
   localparam int FCR_CLR_TX = 2;

   localparam logic [7:0] IIR_RX_DATA = 8'hC4;
   localparam logic [7:0] IIR_THRE    = 8'hC2;
   localparam logic [7:0] IIR_NONE    = 8'hC1;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports: clk_sys, rst_b (synchronous, active low), push/wdata, pop, clear,
//        rdata (head entry), full, empty, count.
// Push while full is only accepted when a pop happens in the same cycle.
// Clear has priority over push and pop.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     clear,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk_sys) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_port_responder.sv
// Bus-side responder for one serial port: 16550-subset register file,
// fixed 8N1 transmitter/receiver, one FIFO per direction, interrupt line.
// Ports: Clock, Reset_L (synchronous, active low), Port_Enable (chip enable),
//        Address[3:0] (index = A3:A1), WE_L (0 = write), DataIn[7:0],
//        DataOut[7:0] (read data, 0 when not enabled), TxD (idle high),
//        RxD (asynchronous), IRQ (active high).
//
// state    | meaning
// TX_IDLE  | line high, waits for a baud tick with TX FIFO non-empty
// TX_START | driving start bit (16 ticks)
// TX_DATA  | shifting 8 data bits LSB first, 16 ticks each
// TX_STOP  | driving stop bit; chains straight into next byte if queued
// RX_IDLE  | waits for 1->0 on synchronised RxD
// RX_START | checks start bit is still low at tick 8 (mid-bit)
// RX_DATA  | samples 8 data bits every 16 ticks at mid-bit
// RX_STOP  | samples stop bit, stores byte, flags framing error if low
module uart_port_responder
   import uart_port_pkg::*;
#(
   parameter int          FIFO_DEPTH      = 16,
   parameter int unsigned DEFAULT_DIVISOR = 27
) (
   input  logic       Clock,
   input  logic       Reset_L,
   input  logic       Port_Enable,
   input  logic [3:0] Address,
   input  logic       WE_L,
   input  logic [7:0] DataIn,
   output logic [7:0] DataOut,
   output logic       TxD,
   input  logic       RxD,
   output logic       IRQ
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIVISOR);

   logic       en_prev_q;
   logic       access, wr_acc, rd_acc, dlab;
   logic [2:0] idx;
   logic       unused_a0;

   logic [1:0] ier_q, ier_d;
   logic [7:0] lcr_q, lcr_d, dll_q, dll_d, dlm_q, dlm_d;
   logic       oe_q, oe_d, fe_q, fe_d;
   logic       irq_q, irq_d;
   logic [7:0] rd_hold_q, rd_hold_d, rdata_mux, lsr, iir;

   logic        div_wr, tick16;
   logic [15:0] divisor, baud_cnt_q, baud_cnt_d;

   logic          thr_push, tx_push, tx_pop, tx_clr, tx_full, tx_empty;
   logic [7:0]    tx_rdata;
   logic [CW-1:0] tx_count;
   logic          rx_pop_req, rx_pop, rx_push, rx_clr, rx_full, rx_empty;
   logic [7:0]    rx_rdata;
   logic [CW-1:0] rx_count;
   logic          lsr_rd, oe_set, fe_set, rx_store, dr, thre, temt;

   tx_state_e  tx_state_q, tx_state_d;
   logic [3:0] tx_tcnt_q, tx_tcnt_d;
   logic [2:0] tx_bcnt_q, tx_bcnt_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       txd_q, txd_d;

   rx_state_e  rx_state_q, rx_state_d;
   logic [3:0] rx_tcnt_q, rx_tcnt_d;
   logic [2:0] rx_bcnt_q, rx_bcnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic       rx_s1_q, rx_s2_q, rx_prev_q;

   assign unused_a0 = Address[0];
   assign idx       = Address[3:1];
   assign dlab      = lcr_q[LCR_DLAB];
   assign divisor   = {dlm_q, dll_q};

   // Register file: one commit per rising edge of Port_Enable.
   always_comb begin
      access     = Port_Enable & ~en_prev_q;
      wr_acc     = access & ~WE_L;
      rd_acc     = access & WE_L;
      ier_d      = ier_q;
      lcr_d      = lcr_q;
      dll_d      = dll_q;
      dlm_d      = dlm_q;
      thr_push   = 1'b0;
      rx_pop_req = 1'b0;
      rx_clr     = 1'b0;
      tx_clr     = 1'b0;
      lsr_rd     = 1'b0;
      div_wr     = 1'b0;
      if (wr_acc) begin
         case (idx)
            IDX_RBR_THR: begin
               if (dlab) begin
                  dll_d  = DataIn;
                  div_wr = 1'b1;
               end else begin
                  thr_push = 1'b1;
               end
            end
            IDX_IER: begin
               if (dlab) begin
                  dlm_d  = DataIn;
                  div_wr = 1'b1;
               end else begin
                  ier_d = DataIn[1:0];
               end
            end
            IDX_IIR_FCR: begin
               rx_clr = DataIn[FCR_CLR_RX];
               tx_clr = DataIn[FCR_CLR_TX];
            end
            IDX_LCR: lcr_d = DataIn;
            default: ;
         endcase
      end
      if (rd_acc) begin
         rx_pop_req = (idx == IDX_RBR_THR) && !dlab;
         lsr_rd     = (idx == IDX_LSR);
      end
   end

   // Baud generator: down-counter reloaded with divisor-1, tick at zero.
   always_comb begin
      tick16 = (divisor != 16'd0) && (baud_cnt_q == 16'd0);
      if (div_wr) begin
         baud_cnt_d = {dlm_d, dll_d} - 16'd1;
      end else if (divisor == 16'd0) begin
         baud_cnt_d = baud_cnt_q;
      end else if (baud_cnt_q == 16'd0) begin
         baud_cnt_d = divisor - 16'd1;
      end else begin
         baud_cnt_d = baud_cnt_q - 16'd1;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_bcnt_d  = tx_bcnt_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (tick16 && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_rdata;
               txd_d      = 1'b0;
               tx_tcnt_d  = 4'd15;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tick16) begin
               if (tx_tcnt_q == 4'd0) begin
                  tx_state_d = TX_DATA;
                  txd_d      = tx_shift_q[0];
                  tx_tcnt_d  = 4'd15;
                  tx_bcnt_d  = 3'd7;
               end else begin
                  tx_tcnt_d = tx_tcnt_q - 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick16) begin
               if (tx_tcnt_q == 4'd0) begin
                  tx_tcnt_d = 4'd15;
                  if (tx_bcnt_q == 3'd0) begin
                     tx_state_d = TX_STOP;
                     txd_d      = 1'b1;
                  end else begin
                     tx_shift_d = tx_shift_q >> 1;
                     txd_d      = tx_shift_q[1];
                     tx_bcnt_d  = tx_bcnt_q - 3'd1;
                  end
               end else begin
                  tx_tcnt_d = tx_tcnt_q - 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick16) begin
               if (tx_tcnt_q == 4'd0) begin
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_shift_d = tx_rdata;
                     txd_d      = 1'b0;
                     tx_tcnt_d  = 4'd15;
                     tx_state_d = TX_START;
                  end else begin
                     txd_d      = 1'b1;
                     tx_state_d = TX_IDLE;
                  end
               end else begin
                  tx_tcnt_d = tx_tcnt_q - 4'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_tcnt_d  = rx_tcnt_q;
      rx_bcnt_d  = rx_bcnt_q;
      rx_shift_d = rx_shift_q;
      rx_store   = 1'b0;
      fe_set     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_tcnt_d  = 4'd7;
            end
         end
         RX_START: begin
            if (tick16) begin
               if (rx_tcnt_q == 4'd0) begin
                  if (!rx_s2_q) begin
                     rx_state_d = RX_DATA;
                     rx_tcnt_d  = 4'd15;
                     rx_bcnt_d  = 3'd7;
                  end else begin
                     rx_state_d = RX_IDLE;
                  end
               end else begin
                  rx_tcnt_d = rx_tcnt_q - 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick16) begin
               if (rx_tcnt_q == 4'd0) begin
                  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                  rx_tcnt_d  = 4'd15;
                  if (rx_bcnt_q == 3'd0) begin
                     rx_state_d = RX_STOP;
                  end else begin
                     rx_bcnt_d = rx_bcnt_q - 3'd1;
                  end
               end else begin
                  rx_tcnt_d = rx_tcnt_q - 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (tick16) begin
               if (rx_tcnt_q == 4'd0) begin
                  rx_store   = 1'b1;
                  fe_set     = ~rx_s2_q;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_tcnt_d = rx_tcnt_q - 4'd1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Status, FIFO handshakes, read mux.
   always_comb begin
      dr      = ~rx_empty;
      thre    = tx_empty;
      temt    = (tx_count == '0) && (tx_state_q == TX_IDLE);
      rx_pop  = rx_pop_req && (rx_count != '0);
      rx_push = rx_store & (~rx_full | rx_pop);
      oe_set  = rx_store & rx_full & ~rx_pop;
      tx_push = thr_push & (~tx_full | tx_pop);
      // An error arriving in the same cycle as the LSR read survives it.
      oe_d    = (oe_q & ~lsr_rd) | oe_set;
      fe_d    = (fe_q & ~lsr_rd) | fe_set;
      irq_d   = (ier_q[0] & dr) | (ier_q[1] & thre);

      lsr           = 8'h00;
      lsr[LSR_DR]   = dr;
      lsr[LSR_OE]   = oe_q;
      lsr[LSR_FE]   = fe_q;
      lsr[LSR_THRE] = thre;
      lsr[LSR_TEMT] = temt;

      if (ier_q[0] & dr) begin
         iir = IIR_RX_DATA;
      end else if (ier_q[1] & thre) begin
         iir = IIR_THRE;
      end else begin
         iir = IIR_NONE;
      end

      case (idx)
         IDX_RBR_THR: rdata_mux = dlab ? dll_q : (rx_empty ? 8'h00 : rx_rdata);
         IDX_IER:     rdata_mux = dlab ? dlm_q : {6'b0, ier_q};
         IDX_IIR_FCR: rdata_mux = iir;
         IDX_LCR:     rdata_mux = lcr_q;
         IDX_LSR:     rdata_mux = lsr;
         default:     rdata_mux = 8'h00;
      endcase

      // The access cycle may pop RX or clear LSR flags, so the value seen on
      // that cycle is held for the rest of the enable period.
      rd_hold_d = access ? rdata_mux : rd_hold_q;
   end

   assign DataOut = (Reset_L && Port_Enable) ? (access ? rdata_mux : rd_hold_q) : 8'h00;
   assign TxD     = txd_q | ~Reset_L;
   assign IRQ     = irq_q;

   uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk_sys (Clock),
      .rst_b   (Reset_L),
      .push    (tx_push),
      .wdata   (DataIn),
      .pop     (tx_pop),
      .clear   (tx_clr),
      .rdata   (tx_rdata),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk_sys (Clock),
      .rst_b   (Reset_L),
      .push    (rx_push),
      .wdata   (rx_shift_q),
      .pop     (rx_pop),
      .clear   (rx_clr),
      .rdata   (rx_rdata),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   always_ff @(posedge Clock) begin
      if (!Reset_L) begin
         en_prev_q  <= 1'b0;
         ier_q      <= 2'b00;
         lcr_q      <= 8'h03;
         dll_q      <= DIV_RST[7:0];
         dlm_q      <= DIV_RST[15:8];
         oe_q       <= 1'b0;
         fe_q       <= 1'b0;
         irq_q      <= 1'b0;
         rd_hold_q  <= 8'h00;
         baud_cnt_q <= DIV_RST - 16'd1;
         tx_state_q <= TX_IDLE;
         tx_tcnt_q  <= 4'd0;
         tx_bcnt_q  <= 3'd0;
         tx_shift_q <= 8'h00;
         txd_q      <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_tcnt_q  <= 4'd0;
         rx_bcnt_q  <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         en_prev_q  <= Port_Enable;
         ier_q      <= ier_d;
         lcr_q      <= lcr_d;
         dll_q      <= dll_d;
         dlm_q      <= dlm_d;
         oe_q       <= oe_d;
         fe_q       <= fe_d;
         irq_q      <= irq_d;
         rd_hold_q  <= rd_hold_d;
         baud_cnt_q <= baud_cnt_d;
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bcnt_q  <= tx_bcnt_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bcnt_q  <= rx_bcnt_d;
         rx_shift_q <= rx_shift_d;
         rx_s1_q    <= RxD;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
      end
   end

endmodule

// File: tb/tb_uart_port_responder.sv
module tb_uart_port_responder;

   logic       clk = 1'b0;
   logic       reset_l;
   logic       port_enable;
   logic [3:0] address;
   logic       we_l;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       txd;
   logic       rxd;
   logic       irq;

   int checks = 0;
   int errors = 0;

   uart_port_responder #(.FIFO_DEPTH(16), .DEFAULT_DIVISOR(27)) dut (
      .Clock       (clk),
      .Reset_L     (reset_l),
      .Port_Enable (port_enable),
      .Address     (address),
      .WE_L        (we_l),
      .DataIn      (data_in),
      .DataOut     (data_out),
      .TxD         (txd),
      .RxD         (rxd),
      .IRQ         (irq)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [2:0] idx, input logic [7:0] data);
      @(negedge clk);
      port_enable = 1'b1;
      address     = {idx, 1'b0};
      we_l        = 1'b0;
      data_in     = data;
      @(negedge clk);
      port_enable = 1'b0;
      we_l        = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [7:0] data);
      @(negedge clk);
      port_enable = 1'b1;
      address     = {idx, 1'b1};
      we_l        = 1'b1;
      #1 data = data_out;
      @(negedge clk);
      port_enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_divisor(input logic [15:0] d);
      bus_write(3'd3, 8'h83);
      bus_write(3'd0, d[7:0]);
      bus_write(3'd1, d[15:8]);
      bus_write(3'd3, 8'h03);
   endtask

   task automatic send_rx_byte(input logic [7:0] b, input logic stop_bit, input int bit_clks);
      rxd = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bit_clks) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (bit_clks) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      logic [7:0] r;
      int bad;
      reset_l = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (txd !== 1'b1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_lines txd=%b irq=%b expected txd=1 irq=0", txd, irq);
      end
      reset_l = 1'b1;
      @(negedge clk);
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("FAIL idle_dataout got %h expected 00", data_out);
      end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL reset_lsr got %h expected 60", r); end
      bus_read(3'd3, r);
      checks++;
      if (r !== 8'h03) begin errors++; $display("FAIL reset_lcr got %h expected 03", r); end
      bus_read(3'd2, r);
      checks++;
      if (r !== 8'hC1) begin errors++; $display("FAIL reset_iir got %h expected C1", r); end
      bus_read(3'd1, r);
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL reset_ier got %h expected 00", r); end
      bus_write(3'd3, 8'h83);
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h1B) begin errors++; $display("FAIL reset_dll got %h expected 1B", r); end
      bus_read(3'd1, r);
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL reset_dlm got %h expected 00", r); end
      bus_read(3'd3, r);
      checks++;
      if (r !== 8'h83) begin errors++; $display("FAIL lcr_dlab got %h expected 83", r); end
      bus_write(3'd3, 8'h03);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (txd !== 1'b1 || irq !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_hold bad_cycles=%0d expected 0", bad); end
   endtask

   task automatic test_tx;
      logic [7:0] b;
      logic [7:0] r;
      logic       exp;
      int n;
      b = 8'h55;
      bus_write(3'd0, b);
      n = 0;
      while (txd !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_timeout txd=%b expected 0", txd); return; end
      n = 0;
      while (txd === 1'b0 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (n != 432) begin errors++; $display("FAIL tx_start_len got %0d expected 432", n); end
      for (int c = 0; c <= 3672; c++) begin
         if (c > 0) @(negedge clk);
         if (c % 432 == 216) begin
            exp = (c / 432 < 8) ? b[c / 432] : 1'b1;
            checks++;
            if (txd !== exp) begin
               errors++;
               $display("FAIL tx_bit%0d got %b expected %b", c / 432, txd, exp);
            end
         end
      end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h20) begin errors++; $display("FAIL tx_lsr_in_stop got %h expected 20", r); end
      repeat (300) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL tx_lsr_done got %h expected 60", r); end
   endtask

   task automatic test_rx;
      logic [7:0] r;
      int bad;
      send_rx_byte(8'hA3, 1'b1, 432);
      send_rx_byte(8'h5A, 1'b1, 432);
      repeat (50) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h61) begin errors++; $display("FAIL rx_lsr_dr got %h expected 61", r); end
      bus_write(3'd1, 8'h01);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq got %b expected 1", irq); end
      bus_read(3'd2, r);
      checks++;
      if (r !== 8'hC4) begin errors++; $display("FAIL rx_iir got %h expected C4", r); end
      @(negedge clk);
      port_enable = 1'b1;
      address     = 4'b0000;
      we_l        = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (data_out !== 8'hA3) bad++;
         @(negedge clk);
      end
      port_enable = 1'b0;
      @(negedge clk);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rbr_hold bad_cycles=%0d expected 0", bad); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h61) begin errors++; $display("FAIL rbr_single_pop lsr=%h expected 61", r); end
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h5A) begin errors++; $display("FAIL rbr_second got %h expected 5A", r); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got %b expected 0", irq); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL rx_lsr_empty got %h expected 60", r); end
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL rbr_empty got %h expected 00", r); end
      bus_write(3'd1, 8'h00);
   endtask

   task automatic test_glitch_fe;
      logic [7:0] r;
      rxd = 1'b0;
      repeat (4 * 27) @(negedge clk);
      rxd = 1'b1;
      repeat (600) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL glitch_lsr got %h expected 60", r); end
      send_rx_byte(8'h3C, 1'b0, 432);
      repeat (50) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h69) begin errors++; $display("FAIL fe_lsr got %h expected 69", r); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h61) begin errors++; $display("FAIL fe_clear got %h expected 61", r); end
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h3C) begin errors++; $display("FAIL fe_byte got %h expected 3C", r); end
   endtask

   task automatic test_overrun;
      logic [7:0] r;
      set_divisor(16'd4);
      for (int i = 0; i < 17; i++) begin
         send_rx_byte(8'h10 + 8'(i), 1'b1, 64);
      end
      repeat (50) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h63) begin errors++; $display("FAIL ovr_lsr got %h expected 63", r); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h61) begin errors++; $display("FAIL ovr_clear got %h expected 61", r); end
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h10) begin errors++; $display("FAIL ovr_first got %h expected 10", r); end
      bus_read(3'd0, r);
      checks++;
      if (r !== 8'h11) begin errors++; $display("FAIL ovr_second got %h expected 11", r); end
      bus_write(3'd2, 8'h02);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL fcr_clr_rx got %h expected 60", r); end
      set_divisor(16'd27);
   endtask

   task automatic test_irq_thre;
      logic [7:0] r;
      bus_write(3'd1, 8'h02);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL thre_irq got %b expected 1", irq); end
      set_divisor(16'd0);
      bus_write(3'd0, 8'hA5);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_drop got %b expected 0", irq); end
      bus_read(3'd2, r);
      checks++;
      if (r !== 8'hC1) begin errors++; $display("FAIL iir_none got %h expected C1", r); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL lsr_held got %h expected 00", r); end
      set_divisor(16'd27);
      repeat (100) @(negedge clk);
      bus_read(3'd2, r);
      checks++;
      if (r !== 8'hC2) begin errors++; $display("FAIL iir_thre got %h expected C2", r); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL thre_irq_back got %b expected 1", irq); end
      repeat (4500) @(negedge clk);
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL irq_tx_done got %h expected 60", r); end
      bus_write(3'd1, 8'h00);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] r;
      int n;
      int bad;
      bus_write(3'd1, 8'h01);
      bus_write(3'd0, 8'h00);
      n = 0;
      while (txd !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL mid_start_timeout txd=%b expected 0", txd); end
      repeat (1000) @(negedge clk);
      reset_l = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd got %b expected 1", txd); end
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      bus_read(3'd1, r);
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL mid_reset_ier got %h expected 00", r); end
      bus_read(3'd5, r);
      checks++;
      if (r !== 8'h60) begin errors++; $display("FAIL mid_reset_lsr got %h expected 60", r); end
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (txd !== 1'b1 || irq !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mid_reset_idle bad_cycles=%0d expected 0", bad); end
   endtask

   initial begin
      reset_l     = 1'b0;
      port_enable = 1'b0;
      address     = 4'h0;
      we_l        = 1'b1;
      data_in     = 8'h00;
      rxd         = 1'b1;
      test_reset();
      test_tx();
      test_rx();
      test_glitch_fe();
      test_overrun();
      test_irq_thre();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
